// File: rtl/hdmi_colorbar_gen_if.sv
// Video bus between the colour bar generator and the SiI9134 parallel input pins.
interface hdmi_colorbar_gen_if;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [15:0] video_rgb;
  logic        frame_start;

  modport master (
    output video_hs,
    output video_vs,
    output video_de,
    output video_rgb,
    output frame_start
  );

  modport slave (
    input video_hs,
    input video_vs,
    input video_de,
    input video_rgb,
    input frame_start
  );
endinterface

// File: rtl/hdmi_colorbar_gen.sv
// 720p-style raster generator with an 8-bar RGB565 colour pattern for the SiI9134.
// The video bus stays idle until the (synchronised) I2C configuration-done flag is high.
// Optional macro COLORBAR_SCROLL_EN: bars scroll left one pixel per frame.
module hdmi_colorbar_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_done_i,
  hdmi_colorbar_gen_if.master  video_o
);

  localparam int unsigned H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW        = $clog2(H_TOTAL);
  localparam int unsigned VW        = $clog2(V_TOTAL);
  localparam int unsigned BAR_W     = H_ACTIVE / 8;
  localparam int unsigned BW        = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned H_ACT_BEG = H_SYNC + H_BP;
  localparam int unsigned H_ACT_END = H_SYNC + H_BP + H_ACTIVE;
  localparam int unsigned V_ACT_BEG = V_SYNC + V_BP;
  localparam int unsigned V_ACT_END = V_SYNC + V_BP + V_ACTIVE;
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            cfg_ok;
  logic            advance;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            h_last, v_last, h_act, v_act;
  logic [BW-1:0]   bar_px_q, bar_px_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [BW-1:0]   off_px;
  logic [2:0]      off_idx;
  logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [15:0]     rgb_q, rgb_d;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Two-flop synchroniser for the config-done level from the I2C clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], cfg_done_i};
  end

  assign cfg_ok = sync_q[1];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cfg_ok)  state_d = StRun;
      StRun:  if (!cfg_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign advance = (state_q == StRun) && cfg_ok;
  assign h_last  = (h_cnt_q == H_LAST);
  assign v_last  = (v_cnt_q == V_LAST);
  assign h_act   = (32'(h_cnt_q) >= H_ACT_BEG) && (32'(h_cnt_q) < H_ACT_END);
  assign v_act   = (32'(v_cnt_q) >= V_ACT_BEG) && (32'(v_cnt_q) < V_ACT_END);

  // Raster counters; cleared on the edge that leaves RUN and held at 0 in IDLE
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (advance) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Bar position of the pixel at h_cnt_q: reloaded with the scroll offset just before the
  // first active pixel, then stepped once per active pixel
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (32'(h_cnt_d) == H_ACT_BEG) begin
      bar_px_d  = off_px;
      bar_idx_d = off_idx;
    end else if (h_act) begin
      if (32'(bar_px_q) == BAR_W - 1) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d  = bar_px_q + BW'(1);
      end
    end
  end

`ifdef COLORBAR_SCROLL_EN
  logic [BW-1:0] off_px_q, off_px_d;
  logic [2:0]    off_idx_q, off_idx_d;

  // Scroll offset kept as (bar, pixel-in-bar) so it wraps at H_ACTIVE without a divider;
  // it steps at the frame wrap so the frame it belongs to starts with the new value
  always_comb begin
    off_px_d  = off_px_q;
    off_idx_d = off_idx_q;
    if (state_q != StRun) begin
      off_px_d  = '0;
      off_idx_d = '0;
    end else if (advance && h_last && v_last) begin
      if (32'(off_px_q) == BAR_W - 1) begin
        off_px_d  = '0;
        off_idx_d = off_idx_q + 3'd1;
      end else begin
        off_px_d  = off_px_q + BW'(1);
      end
    end
  end

  // Scroll offset register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_px_q  <= '0;
      off_idx_q <= '0;
    end else begin
      off_px_q  <= off_px_d;
      off_idx_q <= off_idx_d;
    end
  end

  assign off_px  = off_px_q;
  assign off_idx = off_idx_q;
`else
  assign off_px  = '0;
  assign off_idx = '0;
`endif

  // Counter and bar registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // FSM outputs: decode of the current counters, registered below
  always_comb begin
    hs_d  = ~SYNC_POL;
    vs_d  = ~SYNC_POL;
    de_d  = 1'b0;
    rgb_d = 16'h0000;
    fs_d  = 1'b0;
    if (state_q == StRun) begin
      if (32'(h_cnt_q) < H_SYNC) hs_d = SYNC_POL;
      if (32'(v_cnt_q) < V_SYNC) vs_d = SYNC_POL;
      de_d  = h_act && v_act;
      rgb_d = de_d ? bar_color(bar_idx_q) : 16'h0000;
      fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      rgb_q <= 16'h0000;
      fs_q  <= 1'b0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
    end
  end

  assign video_o.video_hs    = hs_q;
  assign video_o.video_vs    = vs_q;
  assign video_o.video_de    = de_q;
  assign video_o.video_rgb   = rgb_q;
  assign video_o.frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_colorbar_gen.sv
// Directed bench for hdmi_colorbar_gen using a 22x7 raster (16x4 active, 2-pixel bars).
module tb_hdmi_colorbar_gen;

  localparam int HT = 22;
  localparam int VT = 7;
`ifdef COLORBAR_SCROLL_EN
  localparam int NF = 17;
`else
  localparam int NF = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cfg_done;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] bars [8];

  always #5 clk = ~clk;

  hdmi_colorbar_gen_if vif ();

  hdmi_colorbar_gen #(
    .H_ACTIVE (16),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .SYNC_POL (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_done_i (cfg_done),
    .video_o    (vif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".hs"},  32'(vif.video_hs),    32'd0);
    chk({tag, ".vs"},  32'(vif.video_vs),    32'd0);
    chk({tag, ".de"},  32'(vif.video_de),    32'd0);
    chk({tag, ".rgb"}, 32'(vif.video_rgb),   32'd0);
    chk({tag, ".fs"},  32'(vif.frame_start), 32'd0);
  endtask

  function automatic logic [15:0] exp_rgb(input int h, input int v, input int k);
    int x;
    if (h >= 4 && h < 20 && v >= 2 && v < 6) begin
      x = h - 4;
`ifdef COLORBAR_SCROLL_EN
      x = (x + k) % 16;
`else
      x = x + 0 * k;
`endif
      return bars[x / 2];
    end
    return 16'h0000;
  endfunction

  // Starts on the frame_start sample; ends on the next frame_start sample after n frames
  task automatic run_frames(input string tag, input int n, input int k0);
    int bad_hs = 0, bad_vs = 0, bad_de = 0, bad_rgb = 0, bad_fs = 0;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < HT * VT; i++) begin
        int h, v;
        logic e_de;
        h = i % HT;
        v = i / HT;
        e_de = (h >= 4 && h < 20 && v >= 2 && v < 6);
        if (vif.video_hs !== (h < 2)) bad_hs++;
        if (vif.video_vs !== (v < 1)) bad_vs++;
        if (vif.video_de !== e_de) bad_de++;
        if (vif.video_rgb !== exp_rgb(h, v, k0 + f)) bad_rgb++;
        if (vif.frame_start !== (i == 0)) bad_fs++;
        if (vif.video_de === 1'b1) de_cnt++;
        if (vif.video_hs === 1'b1) hs_cnt++;
        if (vif.video_vs === 1'b1) vs_cnt++;
        tick();
      end
    end
    chk({tag, ".hs_err"},  32'(bad_hs),  32'd0);
    chk({tag, ".vs_err"},  32'(bad_vs),  32'd0);
    chk({tag, ".de_err"},  32'(bad_de),  32'd0);
    chk({tag, ".rgb_err"}, 32'(bad_rgb), 32'd0);
    chk({tag, ".fs_err"},  32'(bad_fs),  32'd0);
    chk({tag, ".de_cnt"},  32'(de_cnt),  32'(64 * n));
    chk({tag, ".hs_cnt"},  32'(hs_cnt),  32'(14 * n));
    chk({tag, ".vs_cnt"},  32'(vs_cnt),  32'(22 * n));
    chk({tag, ".fs_next"}, 32'(vif.frame_start), 32'd1);
  endtask

  initial begin
    int idle_bad;
    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

    // Reset values before any clock edge
    rst = 1'b1;
    cfg_done = 1'b0;
    #2;
    chk_idle("reset");
    tick(); tick(); tick();
    rst = 1'b0;

    // Idle hold with cfg_done low
    idle_bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (vif.video_hs !== 1'b0 || vif.video_vs !== 1'b0 || vif.video_de !== 1'b0 ||
          vif.video_rgb !== 16'h0000 || vif.frame_start !== 1'b0) idle_bad++;
    end
    chk("idle_hold", 32'(idle_bad), 32'd0);

    // Start-up: cfg_done rises just after edge N; frame_start and hs after edge N+4
    cfg_done = 1'b1;
    tick(); tick(); tick();
    chk("start.fs_n3", 32'(vif.frame_start), 32'd0);
    chk("start.hs_n3", 32'(vif.video_hs),    32'd0);
    tick();
    chk("start.fs_n4", 32'(vif.frame_start), 32'd1);
    chk("start.hs_n4", 32'(vif.video_hs),    32'd1);
    chk("start.vs_n4", 32'(vif.video_vs),    32'd1);
    run_frames("raster", NF, 0);

    // cfg_done drop mid-line (line 2, pixel index 4 visible at edge D3)
    for (int i = 0; i < 49; i++) tick();
    chk("drop.pre_de", 32'(vif.video_de), 32'd1);
    cfg_done = 1'b0;
    tick(); tick(); tick();
    chk("drop.d3_de",  32'(vif.video_de),  32'd1);
    chk("drop.d3_rgb", 32'(vif.video_rgb), 32'(exp_rgb(8, 2, NF)));
    tick();
    chk_idle("drop.d4");
    for (int i = 0; i < 5; i++) tick();
    chk_idle("drop.hold");

    // Re-assertion restarts from a clean frame with zero scroll offset
    cfg_done = 1'b1;
    tick(); tick(); tick();
    chk("restart.fs_n3", 32'(vif.frame_start), 32'd0);
    tick();
    run_frames("restart", 1, 0);

    // Asynchronous reset during active video
    for (int i = 0; i < 49; i++) tick();
    chk("arst.pre_de", 32'(vif.video_de), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("arst");
    tick(); tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("arst.fs_r3", 32'(vif.frame_start), 32'd0);
    tick();
    chk("arst.fs_r4", 32'(vif.frame_start), 32'd1);
    chk("arst.hs_r4", 32'(vif.video_hs),    32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_colorbar_gen.md
# hdmi_colorbar_gen

Pixel-clock video source that drives the SiI9134 parallel video input with a 720p-style timing raster and an 8-bar RGB565 colour bar pattern. It sits alongside the SiI9134 I2C configuration driver. It consumes that driver's configuration-done flag and holds the video bus idle until register setup has finished. Its outputs go straight to the transmitter's HS/VS/DE/data pins.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 8
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1'b1, asserted level of video_hs/video_vs

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- cfg_done  in  1  configuration-done level from the I2C config driver; comes from another clock domain
- video_hs  out  1  horizontal sync, polarity SYNC_POL
- video_vs  out  1  vertical sync, polarity SYNC_POL
- video_de  out  1  data enable, high on active pixels
- video_rgb  out  16  RGB565 pixel, with R in [15:11], G in [10:5] and B in [4:0]
- frame_start  out  1  one-cycle pulse coincident with h=0, v=0 of every frame

## Operation
Synchronisation:
- cfg_done passes through a 2-flop synchroniser to give cfg_ok.

State machine:
- IDLE: counters are held at 0 and outputs are inactive. Move to RUN when cfg_ok=1.
- RUN: counters advance each clk. Move to IDLE when cfg_ok=0; counters clear on that same edge.

Counters:
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP.
- v_cnt increments when h_cnt wraps. It counts 0..V_TOTAL-1, where V_TOTAL is defined the same way.

Line and frame layout, in order: sync, back porch, active, front porch.
- hs active when h_cnt < H_SYNC.
- vs active when v_cnt < V_SYNC.
- de when H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP ≤ v_cnt < V_SYNC+V_BP+V_ACTIVE.

Colour bars:
- BAR_W = H_ACTIVE/8.
- A bar pixel counter resets at the first active pixel of each line. The bar index (0..7) increments every BAR_W active pixels.
- Colours by index: 0 FFFF white, 1 FFE0 yellow, 2 07FF cyan, 3 07E0 green, 4 F81F magenta, 5 F800 red, 6 001F blue, 7 0000 black.
- video_rgb = 16'h0000 whenever de=0.

Reset and inactive values:
- On reset, all outputs take these values: video_hs=~SYNC_POL, video_vs=~SYNC_POL, video_de=0, video_rgb=0, frame_start=0.
- The state machine resets to IDLE, and the counters and synchroniser reset to 0.
- In IDLE, outputs hold these same reset values.

## Timing
- All outputs are registered and lag the counters by exactly 1 cycle. frame_start is high in the cycle after RUN is entered with h=v=0, and every H_TOTAL·V_TOTAL cycles after that.
- cfg_done rising at edge N: cfg_ok=1 after edge N+2 and RUN from edge N+3. The first frame_start and the first hs assertion are high after edge N+4.
- cfg_done falling while in RUN: after the 2-cycle sync delay, state goes to IDLE. Outputs go to their inactive values one cycle later, mid-line if that is where the raster is. Frame truncation is accepted.
- The h_cnt wrap and v_cnt wrap coincide on the last pixel of a frame. Both counters return to 0 on the same edge.
- rst asserted mid-frame clears everything asynchronously. After release, the first RUN edge needs cfg_ok=1 again, which takes the 2-flop sync latency.

## Configuration
- Macro COLORBAR_SCROLL_EN.
- Defined: a scroll offset register (0..H_ACTIVE-1) increments by 1 at each frame_start, wrapping from H_ACTIVE-1 to 0. Bar selection uses (active pixel index + offset) mod H_ACTIVE, so the bars move left one pixel per frame. The offset resets to 0 on rst and while in IDLE.
- Not defined: the offset logic is absent. Bars are static, with bar 0 starting at the first active pixel.

## Test plan
Use small parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=22), V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7), SYNC_POL=1.
- Idle hold: rst pulse, cfg_done=0 for 500 cycles -> hs=vs=de=0, rgb=0000, no frame_start.
- Start-up: cfg_done rises at edge N -> first frame_start and hs=1 after edge N+4. The next frame_start comes 154 cycles later. hs is high 2 of every 22 cycles. vs is high for 22 cycles per frame.
- Raster/bars: within one frame, exactly 4 lines × 16 de cycles. rgb on each line follows FFFF,FFFF,FFE0,FFE0,07FF,…,0000 (2 pixels per bar). rgb=0000 whenever de=0.
- cfg_done drop mid-line: after the sync delay plus one cycle, all outputs are inactive. On re-assertion, the raster restarts cleanly from a frame_start.
- Async reset during active video: rst asserted between edges -> outputs go inactive immediately, without waiting for a clock edge.
- COLORBAR_SCROLL_EN defined: in frame k (0-based), the first active pixel shows the bar for index (k mod 16)/2. Frame 1 starts FFFF,FFE0,FFE0,…; frame 16 matches frame 0.
